// File: rtl/button_debounce.sv
// Purpose : conditions a raw push-button pin into a debounced level, one-cycle
//           press/release/long-press pulses and a wrapping press counter.
// Latency : DB_CYCLES+2 fclock edges from a settled pin change to pressed/pulse.
// Backpressure: none; free-running, every output is registered and valid each cycle.
//
// Ports:
//   fclock        - sole clock, all state updates on its rising edge
//   rst           - synchronous active-high reset (driven from ~pll_lock)
//   button        - raw asynchronous pin
//   pressed       - debounced level, 1 = pressed
//   press_pulse   - one-cycle pulse on an accepted press
//   release_pulse - one-cycle pulse on an accepted release
//   long_pulse    - one-cycle pulse once a press has lasted LONG_CYCLES
//   press_count   - accepted presses modulo 2^CNT_W
module button_debounce #(
    parameter int DB_CYCLES   = 50000,
    parameter int LONG_CYCLES = 25000000,
    parameter int ACTIVE_LOW  = 1,
    parameter int CNT_W       = 8
) (
    input  logic             fclock,
    input  logic             rst,
    input  logic             button,
    output logic             pressed,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    logic              r_s1;
    logic              r_s2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_pressed;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_long_pulse;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long_done;
    logic [CNT_W-1:0]  r_press_count;

    logic w_b;
    logic w_disagree;
    logic w_accept;
    logic w_press_acc;
    logic w_rel_acc;
    logic w_long_hit;

    // Pin normalised to 1 = pressed before it enters the synchronizer.
    assign w_b = (ACTIVE_LOW != 0) ? ~button : button;

    assign w_disagree  = (r_s2 != r_pressed);
    // Level change is accepted on the DB_CYCLES-th consecutive disagreeing sample.
    assign w_accept    = w_disagree && (r_db_cnt == DB_MAX);
    assign w_press_acc = w_accept && !r_pressed;
    assign w_rel_acc   = w_accept &&  r_pressed;
    // A release landing on the threshold edge wins; long_pulse is suppressed.
    assign w_long_hit  = r_pressed && !r_long_done && (r_hold_cnt == HOLD_MAX) && !w_rel_acc;

    always_ff @(posedge fclock) begin
        if (rst) begin
            r_s1            <= 1'b0;
            r_s2            <= 1'b0;
            r_db_cnt        <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_hold_cnt      <= '0;
            r_long_done     <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_s1 <= w_b;
            r_s2 <= r_s1;

            // Any agreeing sample throws away accumulated debounce progress.
            if (!w_disagree || w_accept) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end

            if (w_accept) begin
                r_pressed <= ~r_pressed;
            end

            r_press_pulse   <= w_press_acc;
            r_release_pulse <= w_rel_acc;
            r_long_pulse    <= w_long_hit;

            if (w_press_acc) begin
                r_press_count <= r_press_count + CNT_W'(1);
            end

            // Hold timer freezes after firing so long_pulse is once per press.
            if (!r_pressed) begin
                r_hold_cnt  <= '0;
                r_long_done <= 1'b0;
            end else begin
                if (!r_long_done) begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
                if (w_long_hit) begin
                    r_long_done <= 1'b1;
                end
            end
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;
    assign press_count   = r_press_count;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    localparam int DB    = 4;
    localparam int LONG  = 20;
    localparam int AL    = 1;
    localparam int CNT_W = 3;
    localparam int VW    = 4 + CNT_W;

    logic             fclock = 1'b0;
    logic             rst    = 1'b1;
    logic             button = 1'b1;
    logic             pressed;
    logic             press_pulse;
    logic             release_pulse;
    logic             long_pulse;
    logic [CNT_W-1:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 fclock = ~fclock;

    button_debounce #(
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG),
        .ACTIVE_LOW (AL),
        .CNT_W      (CNT_W)
    ) dut (
        .fclock       (fclock),
        .rst          (rst),
        .button       (button),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    // ---------------- reference model ----------------
    // Pin delay line of two edges, then a sliding window of the last DB
    // synchronized samples: the level flips when every sample in the window
    // disagrees with the current level. Long press is "edges since rise == LONG".
    bit             m_pin_q[$];
    bit             m_win_q[$];
    bit             m_pressed, m_press, m_rel, m_long;
    bit [CNT_W-1:0] m_count;
    int             m_edge;
    int             m_rise;

    logic [VW-1:0] w_dut;
    logic [VW-1:0] w_mdl;
    assign w_dut = {pressed, press_pulse, release_pulse, long_pulse, press_count};
    assign w_mdl = {m_pressed, m_press, m_rel, m_long, m_count};

    task automatic model_clear();
        m_pin_q = {1'b0, 1'b0};
        m_win_q.delete();
        repeat (DB) m_win_q.push_back(1'b0);
        m_pressed = 0; m_press = 0; m_rel = 0; m_long = 0;
        m_count = '0; m_edge = 0; m_rise = -1;
    endtask

    task automatic model_edge();
        bit b, seen, differ;
        if (rst) begin
            model_clear();
        end else begin
            b = (AL != 0) ? ~button : button;
            seen = m_pin_q[0];
            void'(m_pin_q.pop_front());
            m_pin_q.push_back(b);
            void'(m_win_q.pop_front());
            m_win_q.push_back(seen);
            differ = 1;
            foreach (m_win_q[i]) if (m_win_q[i] == m_pressed) differ = 0;
            m_press = differ && !m_pressed;
            m_rel   = differ &&  m_pressed;
            m_long  = m_pressed && !m_rel && (m_rise >= 0) && (m_edge - m_rise == LONG);
            if (m_press) begin
                m_rise  = m_edge;
                m_count = m_count + 1'b1;
            end
            if (m_rel) m_rise = -1;
            if (differ) m_pressed = !m_pressed;
            m_edge++;
        end
    endtask

    // Drive inputs at the falling edge, advance the model on the rising edge,
    // leave the caller 1ns after the edge to sample outputs.
    task automatic step(input logic b_val, input logic r_val);
        @(negedge fclock);
        button = b_val;
        rst    = r_val;
        @(posedge fclock);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (w_dut !== '0) begin
                n_fail++;
                $display("FAIL reset_zero cycle %0d: got %b want 0", k, w_dut);
            end
        end
        // Button held low (pressed) through reset release.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (press_pulse !== (k == 5)) begin
                n_fail++;
                $display("FAIL reset_held_pulse edge %0d: got %b want %b", k, press_pulse, (k == 5));
            end
            n_checks++;
            if (w_dut !== w_mdl) begin
                n_fail++;
                $display("FAIL reset_held_model edge %0d: got %b want %b", k, w_dut, w_mdl);
            end
        end
        n_checks++;
        if (press_count !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_held_count: got %0d want 1", press_count);
        end
    endtask

    task automatic test_press_release();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (w_dut !== w_mdl) begin
                n_fail++;
                $display("FAIL settle_model cycle %0d: got %b want %b", k, w_dut, w_mdl);
            end
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if ({pressed, press_pulse} !== {(k >= 5), (k == 5)}) begin
                n_fail++;
                $display("FAIL press_timing edge %0d: got %b%b want %b%b", k, pressed, press_pulse, (k >= 5), (k == 5));
            end
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if ({pressed, release_pulse} !== {(k < 5), (k == 5)}) begin
                n_fail++;
                $display("FAIL release_timing edge %0d: got %b%b want %b%b", k, pressed, release_pulse, (k < 5), (k == 5));
            end
            n_checks++;
            if (w_dut !== w_mdl) begin
                n_fail++;
                $display("FAIL release_model edge %0d: got %b want %b", k, w_dut, w_mdl);
            end
        end
    endtask

    task automatic test_bounce();
        bit lvl;
        repeat (3) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 22; i++) begin
            lvl = (i < 12) ? bit'((i / 3) % 2) : 1'b1;
            step(lvl, 1'b0);
            n_checks++;
            if (w_dut !== '0) begin
                n_fail++;
                $display("FAIL bounce_quiet cycle %0d: got %b want 0", i, w_dut);
            end
            n_checks++;
            if (w_dut !== w_mdl) begin
                n_fail++;
                $display("FAIL bounce_model cycle %0d: got %b want %b", i, w_dut, w_mdl);
            end
        end
    endtask

    task automatic test_long_press();
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL long_press_start: got no press_pulse want one within 20 cycles");
        end
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (long_pulse !== (k == LONG)) begin
                n_fail++;
                $display("FAIL long_timing E+%0d: got %b want %b", k, long_pulse, (k == LONG));
            end
            n_checks++;
            if (w_dut !== w_mdl) begin
                n_fail++;
                $display("FAIL long_model E+%0d: got %b want %b", k, w_dut, w_mdl);
            end
        end
        repeat (10) step(1'b1, 1'b0);
        n_checks++;
        if (pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL long_release: got pressed=%b want 0", pressed);
        end
    endtask

    task automatic test_release_collision();
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL collide_start: got no press_pulse want one within 20 cycles");
        end
        // Pin released before edge E+15 so pressed falls exactly at E+LONG.
        for (int k = 1; k <= 26; k++) begin
            step((k >= 15) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if ({release_pulse, long_pulse} !== {(k == 20), 1'b0}) begin
                n_fail++;
                $display("FAIL collide E+%0d: got rel=%b long=%b want rel=%b long=0", k, release_pulse, long_pulse, (k == 20));
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [CNT_W-1:0] exp_c;
        repeat (3) step(1'b1, 1'b1);
        for (int p = 1; p <= 9; p++) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b0, 1'b0);
                exp_c = (i >= 5) ? CNT_W'(p) : CNT_W'(p - 1);
                n_checks++;
                if ({press_pulse, press_count} !== {(i == 5), exp_c}) begin
                    n_fail++;
                    $display("FAIL count press %0d edge %0d: got pulse=%b cnt=%0d want pulse=%b cnt=%0d",
                             p, i, press_pulse, press_count, (i == 5), exp_c);
                end
            end
            repeat (8) step(1'b1, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (w_dut !== '0) begin
                n_fail++;
                $display("FAIL count_reset cycle %0d: got %b want 0", i, w_dut);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (w_dut !== w_mdl) begin
                n_fail++;
                $display("FAIL count_after_reset cycle %0d: got %b want %b", i, w_dut, w_mdl);
            end
        end
    endtask

    task automatic test_random();
        bit lvl;
        int len;
        for (int seg = 0; seg < 90; seg++) begin
            lvl = bit'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 10));
            for (int i = 0; i < len; i++) begin
                step(lvl, 1'b0);
                n_checks++;
                if (w_dut !== w_mdl) begin
                    n_fail++;
                    $display("FAIL random_model seg %0d cycle %0d: got %b want %b", seg, i, w_dut, w_mdl);
                end
                n_checks++;
                if ($countones({press_pulse, release_pulse, long_pulse}) > 1) begin
                    n_fail++;
                    $display("FAIL pulse_exclusive seg %0d: got %b%b%b want at most one",
                             seg, press_pulse, release_pulse, long_pulse);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_press_release();
        test_bounce();
        test_long_press();
        test_release_collision();
        test_count_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
